// File: rtl/mole_game_if.sv
`timescale 1ns/1ps
// mole_game_if
// Bundles the signals between the input front end, the mole game core and
// the display/LED logic.
//   eval_now      front end -> core : one-cycle guess strobe
//   user_guess    front end -> core : guessed hole (0..4), valid with eval_now
//   mole_pos      core -> display   : current mole hole (0..4)
//   mole_visible  core -> display   : 1 while the mole is up
//   score         core -> display   : hit count, saturating at 255
//   lives         core -> display   : remaining lives
//   hit_flag      core -> display   : held through the indication after a hit
//   miss_flag     core -> display   : held through the indication after a miss
//   game_over     core -> display   : game has ended, waits for reset
// Modports: master = front end / observer side, slave = game core.
interface mole_game_if;
    logic       eval_now;
    logic [2:0] user_guess;
    logic [2:0] mole_pos;
    logic       mole_visible;
    logic [7:0] score;
    logic [2:0] lives;
    logic       hit_flag;
    logic       miss_flag;
    logic       game_over;

    modport master (
        output eval_now, user_guess,
        input  mole_pos, mole_visible, score, lives,
               hit_flag, miss_flag, game_over
    );

    modport slave (
        input  eval_now, user_guess,
        output mole_pos, mole_visible, score, lives,
               hit_flag, miss_flag, game_over
    );
endinterface

// File: rtl/mole_game_core.sv
`timescale 1ns/1ps
// mole_game_core
// Whack-a-mole round sequencer. Cycles GAP (mole hidden) -> UP (mole shown,
// guess judged) -> SHOW (hit/miss indication held) -> GAP ..., and parks in
// OVER once the last life is lost. The hole for each round comes from an
// 8-bit Fibonacci LFSR that free-runs in every state except OVER.
// Ports:
//   clk   system clock, all state on the rising edge
//   rst   asynchronous, active-high reset
//   bus   mole_game_if.slave: eval_now/user_guess in; mole_pos,
//         mole_visible, score, lives, hit_flag, miss_flag, game_over out
module mole_game_core #(
    parameter int         GAP_CYCLES  = 50_000_000,
    parameter int         UP_CYCLES   = 100_000_000,
    parameter int         SHOW_CYCLES = 25_000_000,
    parameter int         START_LIVES = 3,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    mole_game_if.slave  bus
);

    localparam logic [1:0] ST_GAP  = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_SHOW = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    // The shared timer only has to reach the longest phase length minus one.
    localparam int MAX_GU  = (GAP_CYCLES > UP_CYCLES) ? GAP_CYCLES : UP_CYCLES;
    localparam int MAX_CYC = (MAX_GU > SHOW_CYCLES) ? MAX_GU : SHOW_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] UP_LAST   = TW'(UP_CYCLES - 1);
    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);

    // Folds the 3 low LFSR bits onto holes 0..4 (5,6,7 -> 2,3,4).
    function automatic logic [2:0] map_hole(input logic [7:0] v);
        if (v[2:0] < 3'd5)
            return v[2:0];
        else
            return v[2:0] - 3'd3;
    endfunction

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [7:0]    lfsr;
    logic [7:0]    lfsr_next;
    logic [2:0]    mole_pos_q;
    logic [7:0]    score_q;
    logic [2:0]    lives_q;
    logic          hit_q;
    logic          miss_q;
    logic          guess_valid;

    // Taps x^8+x^6+x^5+x^4+1 -> bits 7,5,4,3, shifting towards the MSB.
    assign lfsr_next   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // Out-of-range guesses are dropped entirely so the UP timer keeps going.
    assign guess_valid = bus.eval_now && (bus.user_guess < 3'd5);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_GAP;
            timer      <= '0;
            lfsr       <= LFSR_SEED;
            mole_pos_q <= map_hole(LFSR_SEED);
            score_q    <= 8'd0;
            lives_q    <= 3'(START_LIVES);
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            if (state != ST_OVER)
                lfsr <= lfsr_next;

            case (state)
                ST_GAP: begin
                    if (timer == GAP_LAST) begin
                        mole_pos_q <= map_hole(lfsr);
                        timer      <= '0;
                        state      <= ST_UP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                ST_UP: begin
                    // A guess on the timeout cycle wins over the timeout.
                    if (guess_valid) begin
                        if (bus.user_guess == mole_pos_q) begin
                            if (score_q != 8'hFF)
                                score_q <= score_q + 8'd1;
                            hit_q <= 1'b1;
                        end else begin
                            lives_q <= lives_q - 3'd1;
                            miss_q  <= 1'b1;
                        end
                        timer <= '0;
                        state <= ST_SHOW;
                    end else if (timer == UP_LAST) begin
                        lives_q <= lives_q - 3'd1;
                        miss_q  <= 1'b1;
                        timer   <= '0;
                        state   <= ST_SHOW;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                ST_SHOW: begin
                    if (timer == SHOW_LAST) begin
                        hit_q  <= 1'b0;
                        miss_q <= 1'b0;
                        timer  <= '0;
                        // lives reaches 0 only through a miss, so OVER is
                        // always entered before another decrement can happen.
                        state  <= (lives_q == 3'd0) ? ST_OVER : ST_GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                // NOTE: the explicit default keeps the case full; OVER holds
                // every register until reset.
                default: begin
                end
            endcase
        end
    end

    assign bus.mole_pos     = mole_pos_q;
    assign bus.mole_visible = (state == ST_UP);
    assign bus.score        = score_q;
    assign bus.lives        = lives_q;
    assign bus.hit_flag     = hit_q;
    assign bus.miss_flag    = miss_q;
    assign bus.game_over    = (state == ST_OVER);

endmodule
